// File: rtl/bcd_sched.sv
// Round-robin scheduler sharing one binary-to-BCD converter between the hour,
// minute and second fields, holding the latest BCD result for each field.
module bcd_sched #(
    parameter int BIN_W    = 6,
    parameter int BCD_W    = 8,
    parameter int CONV_LAT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] hour,
    input  logic [BIN_W-1:0] minu,
    input  logic [BIN_W-1:0] seco,
    input  logic             hour_vld,
    input  logic             minu_vld,
    input  logic             seco_vld,
    output logic [BIN_W-1:0] conv_bin,
    output logic             conv_vld,
    input  logic [BCD_W-1:0] conv_bcd,
    output logic [BCD_W-1:0] hour_bcd,
    output logic [BCD_W-1:0] minu_bcd,
    output logic [BCD_W-1:0] seco_bcd,
    output logic [2:0]       bcd_upd,
    output logic             busy
);
    localparam int CNT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    // Field index equals its bcd_upd bit: 2 hour, 1 minu, 0 seco.
    state_t           state;
    logic [2:0]       vld;
    logic [2:0]       pend;
    logic [2:0]       req;
    logic [1:0]       ptr;
    logic [1:0]       gnt;
    logic [1:0]       pick;
    logic [1:0]       cand1;
    logic [1:0]       cand2;
    logic             found;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] val   [3];
    logic [BIN_W-1:0] snap  [3];
    logic [BIN_W-1:0] issue_val;
    logic [BCD_W-1:0] bcd   [3];

    assign vld    = {hour_vld, minu_vld, seco_vld};
    assign val[2] = hour;
    assign val[1] = minu;
    assign val[0] = seco;

    assign hour_bcd = bcd[2];
    assign minu_bcd = bcd[1];
    assign seco_bcd = bcd[0];

    function automatic logic [1:0] next_field(input logic [1:0] f);
        return (f == 2'd0) ? 2'd2 : f - 2'd1;
    endfunction

    // In IDLE a request arriving this cycle is granted directly, saving the
    // cycle it would take to land in the pending flag.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        req   = (state == IDLE) ? (pend | vld) : pend;
        cand1 = next_field(ptr);
        cand2 = next_field(cand1);
        found = 1'b1;
        pick  = ptr;
        if (req[ptr])        pick = ptr;
        else if (req[cand1]) pick = cand1;
        else if (req[cand2]) pick = cand2;
        else                 found = 1'b0;
        issue_val = (state == IDLE && vld[pick]) ? val[pick] : snap[pick];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            conv_bin <= '0;
            conv_vld <= 1'b0;
            bcd_upd  <= 3'b000;
            busy     <= 1'b0;
            pend     <= 3'b000;
            ptr      <= 2'd2;
            gnt      <= 2'd2;
            cnt      <= '0;
            // NOTE: the three-entry snapshot/BCD arrays are plain flops, so they are reset like any other state.
            for (int f = 0; f < 3; f++) begin
                snap[f] <= '0;
                bcd[f]  <= '0;
            end
        end else begin
            conv_vld <= 1'b0;
            bcd_upd  <= 3'b000;
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= ISSUE;
                        conv_vld <= 1'b1;
                        conv_bin <= issue_val;
                        gnt      <= pick;
                        ptr      <= next_field(pick);
                        busy     <= 1'b1;
                    end
                end
                ISSUE: begin
                    pend[gnt] <= 1'b0;
                    cnt       <= CNT_LOAD;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        bcd[gnt]     <= conv_bcd;
                        bcd_upd[gnt] <= 1'b1;
                        if (found) begin
                            state    <= ISSUE;
                            conv_vld <= 1'b1;
                            conv_bin <= issue_val;
                            gnt      <= pick;
                            ptr      <= next_field(pick);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // NOTE: this capture comes after the ISSUE clear, so a same-cycle request keeps its pending flag (last non-blocking write wins).
            for (int f = 0; f < 3; f++) begin
                if (vld[f]) begin
                    snap[f] <= val[f];
                    pend[f] <= 1'b1;
                end
            end
        end
    end
endmodule
